// File: rtl/codes_pkg.sv
// Shared Binary/Gray code helpers and mode encodings.
// Used by the converter pipe and by the Gray-counter and async-FIFO blocks.
package codes_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Widest code the helpers handle. Callers zero-extend narrower values and
  // slice the result back to their own width. Zero upper bits do not change
  // either transform.
  localparam int CODES_MAXW = 64;

  typedef logic [CODES_MAXW-1:0] codes_word_t;

  function automatic codes_word_t bin2gray(input codes_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB downwards. Each binary bit is the parity of all
  // Gray bits at or above it.
  function automatic codes_word_t gray2bin(input codes_word_t g);
    codes_word_t b;
    b[CODES_MAXW-1] = g[CODES_MAXW-1];
    for (int i = CODES_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/codes_fifo_nd.sv
// Circular-buffer FIFO with an occupancy count and registered storage.
// A push while full, or a pop while empty, is ignored.
module codes_fifo_nd #(
  parameter int p_width = 9,
  parameter int p_depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [p_width-1:0]         wdata,
  output logic [p_width-1:0]         rdata,
  output logic [$clog2(p_depth):0]   count
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(p_depth);
  localparam logic [PW-1:0] LAST_PTR   = PW'(p_depth - 1);

  logic [p_width-1:0] mem [p_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state is assigned with <= only, so every register sees the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared on reset too. That costs reset fan-out but
      // guarantees that no entry written before reset can ever reach rdata.
      for (int i = 0; i < p_depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/codes_gray_conv_pipe.sv
// Registered Binary<->Gray converter with per-transaction mode bit and val/rdy
// handshakes. Results queue in a small FIFO for full throughput.
module codes_gray_conv_pipe
  import codes_pkg::*;
#(
  parameter int p_nbits = 8,
  parameter int p_depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic                       in_mode,
  input  logic [p_nbits-1:0]         in_data,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic                       out_mode,
  output logic [p_nbits-1:0]         out_data,
  output logic [$clog2(p_depth):0]   count
);

  localparam int CW = $clog2(p_depth) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(p_depth);

  generate
    if (p_nbits < 2 || p_nbits > CODES_MAXW) begin : g_bad_width
      $error("codes_gray_conv_pipe: p_nbits out of range");
    end
    if (p_depth < 2 || (p_depth & (p_depth - 1)) != 0) begin : g_bad_depth
      $error("codes_gray_conv_pipe: p_depth must be a power of two >= 2");
    end
  endgenerate

  typedef struct packed {
    logic               mode;
    logic [p_nbits-1:0] data;
  } entry_t;

  codes_word_t conv_wide;
  entry_t      wr_entry;
  entry_t      rd_entry;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    // NOTE: default first, so no branch leaves conv_wide unassigned and no
    // latch is inferred.
    conv_wide = '0;
    if (in_mode == MODE_G2B) begin
      conv_wide = gray2bin(codes_word_t'(in_data));
    end else begin
      conv_wide = bin2gray(codes_word_t'(in_data));
    end
  end

  assign wr_entry = '{mode: in_mode, data: conv_wide[p_nbits-1:0]};

  // Readiness comes only from registered occupancy. A pop in the same cycle
  // does not free a slot for a push into a full buffer.
  assign in_rdy  = (count != FULL_COUNT);
  assign out_val = (count != '0);
  assign do_push = in_val && in_rdy;
  assign do_pop  = out_val && out_rdy;

  codes_fifo_nd #(
    .p_width ($bits(entry_t)),
    .p_depth (p_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count)
  );

  // Outputs are zeroed when empty, so an old head entry is never visible.
  assign out_data = out_val ? rd_entry.data : '0;
  assign out_mode = out_val ? rd_entry.mode : 1'b0;

endmodule

// File: tb/tb_codes_gray_conv_pipe.sv
// Scoreboard bench: a 4-bit and an 8-bit converter share one stimulus stream
// and are compared against an independent model on every falling edge.
module tb_codes_gray_conv_pipe;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val;
  logic       in_mode;
  logic [7:0] in_data;
  logic       out_rdy;

  logic       in_rdy4, out_val4, out_mode4;
  logic [3:0] out_data4;
  logic [1:0] count4;
  logic       in_rdy8, out_val8, out_mode8;
  logic [7:0] out_data8;
  logic [1:0] count8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  codes_gray_conv_pipe #(.p_nbits(4), .p_depth(DEPTH)) u_dut4 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy4), .in_mode(in_mode),
    .in_data(in_data[3:0]), .out_val(out_val4), .out_rdy(out_rdy),
    .out_mode(out_mode4), .out_data(out_data4), .count(count4)
  );

  codes_gray_conv_pipe #(.p_nbits(8), .p_depth(DEPTH)) u_dut8 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy8), .in_mode(in_mode),
    .in_data(in_data), .out_val(out_val8), .out_rdy(out_rdy),
    .out_mode(out_mode8), .out_data(out_data8), .count(count8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent model: each binary bit is the parity of the Gray bits at or above it.
  function automatic logic [7:0] m_b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic logic [7:0] m_conv(input logic m, input logic [7:0] d);
    return m ? m_g2b(d) : m_b2g(d);
  endfunction

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      q8.delete();
      check("rst_out_val8", 32'(out_val8), 32'd0);
      check("rst_count8",   32'(count8),   32'd0);
      check("rst_in_rdy8",  32'(in_rdy8),  32'd1);
      check("rst_data8",    32'({out_mode8, out_data8}), 32'd0);
      check("rst_out_val4", 32'(out_val4), 32'd0);
      check("rst_data4",    32'({out_mode4, out_data4}), 32'd0);
    end else begin
      logic push_m, pop4_m, pop8_m;
      check("count8",   32'(count8),   32'(q8.size()));
      check("in_rdy8",  32'(in_rdy8),  32'(q8.size() != DEPTH));
      check("out_val8", 32'(out_val8), 32'(q8.size() != 0));
      check("count4",   32'(count4),   32'(q4.size()));
      check("in_rdy4",  32'(in_rdy4),  32'(q4.size() != DEPTH));
      check("out_val4", 32'(out_val4), 32'(q4.size() != 0));
      if (q8.size() != 0) check("head8", 32'({out_mode8, out_data8}), 32'(q8[0]));
      else                check("idle8", 32'({out_mode8, out_data8}), 32'd0);
      if (q4.size() != 0) check("head4", 32'({out_mode4, out_data4}), 32'(q4[0]));
      push_m = in_val && (q8.size() != DEPTH);
      pop8_m = out_rdy && (q8.size() != 0);
      pop4_m = out_rdy && (q4.size() != 0);
      if (pop8_m) void'(q8.pop_front());
      if (pop4_m) void'(q4.pop_front());
      if (push_m) begin
        logic [7:0] e8, e4;
        e8 = m_conv(in_mode, in_data);
        e4 = m_conv(in_mode, {4'h0, in_data[3:0]});
        q8.push_back({in_mode, e8});
        q4.push_back({in_mode, e4[3:0]});
      end
    end
  end

  // Drive one item and hold it until accepted; returns #1 after the push edge.
  task automatic send(input logic m, input logic [7:0] d);
    int n = 0;
    in_val  = 1'b1;
    in_mode = m;
    in_data = d;
    while (!in_rdy8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_rdy = 1'b1;
    while ((q8.size() != 0 || q4.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; in_mode = 1'b0; in_data = '0; out_rdy = 1'b0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Bin-to-Gray: first result visible the cycle after acceptance.
    out_rdy = 1'b1;
    send(1'b0, 8'h02);
    check("lat_val4",  32'(out_val4),  32'd1);
    check("b2g_0010",  32'(out_data4), 32'h3);
    check("b2g_mode",  32'(out_mode4), 32'd0);
    @(posedge clk); #1;
    for (int x = 0; x < 16; x++) send(1'b0, 8'(x));
    @(posedge clk); #1;

    // Gray-to-bin, including 1011 -> 1101, then round trip over all codes.
    send(1'b1, 8'h0B);
    check("g2b_1011", 32'(out_data4), 32'hD);
    check("g2b_mode", 32'(out_mode4), 32'd1);
    for (int x = 0; x < 16; x++) send(1'b1, m_b2g(8'(x)));
    drain();

    // Back-to-back mixed modes at full throughput on the 8-bit unit.
    send(1'b0, 8'hFF);
    check("bb_first",  32'({out_mode8, out_data8}), 32'h080);
    send(1'b1, 8'h80);
    check("bb_second", 32'({out_mode8, out_data8}), 32'h1FF);
    check("bb_count",  32'(count8), 32'd1);
    drain();

    // Back-pressure: two accepted, third held until a slot frees.
    out_rdy = 1'b0;
    send(1'b0, 8'h11);
    send(1'b1, 8'h22);
    in_val = 1'b1; in_mode = 1'b0; in_data = 8'h33;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_rdy",   32'(in_rdy8), 32'd0);
      check("full_count", 32'(count8),  32'd2);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("freed_rdy", 32'(in_rdy8), 32'd1);
    check("freed_cnt", 32'(count8),  32'd1);
    @(posedge clk); #1;
    in_val = 1'b0;
    check("third_in", 32'(count8), 32'd1);
    drain();

    // Asynchronous reset mid-cycle with a full buffer.
    out_rdy = 1'b0;
    send(1'b0, 8'h5A);
    send(1'b1, 8'hA5);
    check("pre_rst_count", 32'(count8), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("arst_val8",  32'(out_val8), 32'd0);
    check("arst_cnt8",  32'(count8),   32'd0);
    check("arst_val4",  32'(out_val4), 32'd0);
    check("arst_data8", 32'(out_data8), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with random back-pressure.
    fork
      begin
        repeat (600) begin
          @(posedge clk); #1;
          out_rdy = 1'($urandom_range(0, 1));
        end
      end
      begin
        repeat (200) begin
          send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
    join
    drain();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/codes_gray_conv_pipe.md
Name: codes_gray_conv_pipe

Overview:
Parametrised, registered Binary/Gray code converter with val/rdy handshakes on both sides. Each transaction carries its own mode bit: binary-to-Gray or Gray-to-binary. Results are buffered in a small output FIFO, giving full throughput under back-pressure. Used wherever multi-bit counters or pointers cross into or out of Gray encoding, for example async FIFO pointers and rotary encoders.

Parameters:
p_nbits   8   data width in bits; must be >= 2
p_depth   2   output FIFO entries; power of two, >= 2

Ports:
clk       input   1         clock; all state updates on rising edge
rst       input   1         asynchronous, active-high reset
in_val    input   1         input transaction valid
in_rdy    output  1         block can accept an input this cycle
in_mode   input   1         0 = binary-to-Gray, 1 = Gray-to-binary
in_data   input   p_nbits   value to convert
out_val   output  1         converted result valid
out_rdy   input   1         consumer accepts the result this cycle
out_mode  output  1         mode of the transaction at the FIFO head
out_data  output  p_nbits   converted value at the FIFO head
count     output  clog2(p_depth)+1   FIFO occupancy

Behaviour:
- Reset (async, active-high): FIFO pointers and count go to 0; all storage entries clear to 0. While rst is high and after release: out_val=0, out_data=0, out_mode=0, count=0, in_rdy=1.
- Conversion is combinational on the input side.
  - Bin-to-Gray: g = b ^ (b >> 1).
  - Gray-to-bin: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i] for i descending. This is a full prefix XOR, not the one-level shift.
  - Result width is exactly p_nbits. No sign handling; inputs are unsigned.
- Push: occurs when in_val && in_rdy. Writes {in_mode, converted in_data} to the tail entry.
- Pop: occurs when out_val && out_rdy. Advances the head.
- in_rdy = (count != p_depth). Readiness depends only on registered state; there is no combinational path from out_rdy. When full, no push is accepted, even if a pop happens in the same cycle.
- out_val = (count != 0). out_data and out_mode show the head entry. No bypass, so an empty FIFO shows out_val=0 even when in_val=1.
- Latency: an input accepted in cycle N appears with out_val=1 in cycle N+1, provided it is at the head.
- Simultaneous push and pop when 0 < count < p_depth: count is unchanged and both pointers advance.
- Pointers wrap modulo p_depth.
- Order is strictly FIFO. Mixed modes are allowed back to back, and each result keeps its own mode.
- Holding values: out_data and out_mode stay stable while out_val && !out_rdy. in_data is sampled only on the push edge.
- Reset asserted mid-stream discards all buffered results immediately, without waiting for a clock edge.

Decomposition:
- Shared package codes_pkg:
  - localparams MODE_B2G=1'b0 and MODE_G2B=1'b1
  - pure functions bin2gray(b) and gray2bin(g), width-generic via parameterised function or let
  - reused by future Gray-counter and async-FIFO blocks
- One sub-module, codes_fifo_nd: parametrised circular buffer with count, taking p_nbits+1 bits of payload and using the same clk/rst convention.
- The top level holds the conversion mux and the handshake glue.

Test Plan:
1. p_nbits=4, reset held 3 cycles, then released -> out_val=0, in_rdy=1, count=0, out_data=0 for all cycles.
2. p_nbits=4, send mode 0 with data 0010, out_rdy=1 -> next cycle out_val=1, out_data=0011, out_mode=0. Sweep all 16 codes and compare with bin2gray; 0111->0100 and 1111->1000.
3. p_nbits=4, send mode 1 with data 1011 -> out_data=1101. Round-trip check: for all 16 values, gray2bin(bin2gray(x))==x.
4. p_nbits=8, back-to-back mode 0 with 0xFF, then mode 1 with 0x80, out_rdy=1 -> out_data sequence 0x80 then 0xFF. Modes echo 0 then 1, and throughput is 1 per cycle.
5. p_depth=2, out_rdy=0, push 3 items -> the first two are accepted, count=2, in_rdy=0, and the third is held. Raise out_rdy -> the third is accepted one cycle after the first pop, and order is preserved.
6. With count=2 and out_val=1, assert rst mid-cycle (asynchronously) -> out_val=0 and count=0 before the next clock edge. After release, no stale data is ever presented.
